sobel_window: RTL and testbench

SOBEL_WINDOW -- requirements
Module: sobel_window

---
 rtl/sobel_window.sv | 171 +++++++++++++++++
 tb/tb_sobel_window.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window.sv
// sobel_window
// Holds the 3x3 pixel neighbourhood used by a Sobel filter. A load_initial
// command fills all nine pixels from image memory. A move_done command
// shifts the window one step right, left or down, then fetches only the
// three pixels that enter the window.
//
// Ports
//   clk          rising-edge clock, the only clock
//   n_reset      synchronous reset, active HIGH despite its name
//   load_initial pulse: start a full 9-pixel fill
//   move_done    pulse: window moved one step in 'direction'
//   direction    01 right, 10 left, 11 down, 00 invalid
//   pixel_in     pixel read from image SRAM
//   pixel_valid  pixel_in is valid this cycle
//   pixel_req    high while the block is waiting for pixels
//   window       3x3 window, row-major, w0 (top-left) in the LSBs
//   window_valid one-cycle pulse: the window is complete
//   busy         high while filling (FILL9 or FILL3)
//   error        sticky protocol-violation flag, cleared only by reset
module sobel_window #(
  parameter int PIXEL_W = 8
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 load_initial,
  input  logic                 move_done,
  input  logic [1:0]           direction,
  input  logic [PIXEL_W-1:0]   pixel_in,
  input  logic                 pixel_valid,
  output logic                 pixel_req,
  output logic [9*PIXEL_W-1:0] window,
  output logic                 window_valid,
  output logic                 busy,
  output logic                 error
);

  typedef enum logic [1:0] {IDLE, FILL9, FILL3, DONE} state_e;

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [1:0]         dir_q, dir_d;
  logic [PIXEL_W-1:0] win_q [9];
  logic [PIXEL_W-1:0] win_d [9];
  logic               err_q, err_d;
  logic [3:0]         slot;

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the
    // case can leave it unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    win_d   = win_q;
    err_d   = err_q;
    slot    = '0;

    unique case (state_q)
      IDLE: begin
        // load_initial wins over a simultaneous move_done.
        if (load_initial) begin
          state_d = FILL9;
          cnt_d   = '0;
        end else if (move_done) begin
          if (direction == DIR_NONE) begin
            err_d = 1'b1;
          end else begin
            dir_d   = direction;
            cnt_d   = '0;
            state_d = FILL3;
            // Shift the surviving pixels now. The vacated column or row
            // keeps stale data until FILL3 overwrites it.
            for (int r = 0; r < 3; r++) begin
              unique case (direction)
                DIR_RIGHT: begin
                  win_d[3*r]   = win_q[3*r+1];
                  win_d[3*r+1] = win_q[3*r+2];
                end
                DIR_LEFT: begin
                  win_d[3*r+2] = win_q[3*r+1];
                  win_d[3*r+1] = win_q[3*r];
                end
                default: begin
                  if (r < 2) begin
                    win_d[3*r]   = win_q[3*r+3];
                    win_d[3*r+1] = win_q[3*r+4];
                    win_d[3*r+2] = win_q[3*r+5];
                  end
                end
              endcase
            end
          end
        end
      end

      FILL9: begin
        if (load_initial || move_done) err_d = 1'b1;
        if (pixel_valid) begin
          for (int i = 0; i < 9; i++) begin
            if (cnt_q == 4'(i)) win_d[i] = pixel_in;
          end
          if (cnt_q == 4'd8) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      FILL3: begin
        if (load_initial || move_done) err_d = 1'b1;
        // Slot vacated by the shift for row/column k = cnt_q.
        unique case (dir_q)
          DIR_RIGHT: slot = cnt_q * 4'd3 + 4'd2;
          DIR_LEFT:  slot = cnt_q * 4'd3;
          default:   slot = cnt_q + 4'd6;
        endcase
        if (pixel_valid) begin
          for (int i = 0; i < 9; i++) begin
            if (slot == 4'(i)) win_d[i] = pixel_in;
          end
          if (cnt_q == 4'd2) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      DONE: begin
        if (load_initial || move_done) err_d = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_NONE;
      // NOTE: the window is a register file rather than a RAM, and the
      // reset value 0 is visible on the output, so every entry is cleared.
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      win_q   <= win_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 9; i++) window[i*PIXEL_W +: PIXEL_W] = win_q[i];
  end

  assign busy         = (state_q == FILL9) || (state_q == FILL3);
  assign pixel_req    = busy;
  assign window_valid = (state_q == DONE);
  assign error        = err_q;

endmodule

// File: tb/tb_sobel_window.sv
module tb_sobel_window;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          load_initial;
  logic          move_done;
  logic [1:0]    direction;
  logic [PW-1:0] pixel_in;
  logic          pixel_valid;
  logic          pixel_req;
  logic [9*PW-1:0] window;
  logic          window_valid;
  logic          busy;
  logic          error;

  int errors = 0;
  int checks = 0;

  sobel_window #(.PIXEL_W(PW)) dut (
    .clk(clk), .n_reset(n_reset), .load_initial(load_initial),
    .move_done(move_done), .direction(direction), .pixel_in(pixel_in),
    .pixel_valid(pixel_valid), .pixel_req(pixel_req), .window(window),
    .window_valid(window_valid), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [9*PW-1:0] obs,
                       input logic [9*PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [9*PW-1:0] pk(input int a0, a1, a2, a3, a4,
                                         a5, a6, a7, a8);
    pk = {PW'(a8), PW'(a7), PW'(a6), PW'(a5), PW'(a4),
          PW'(a3), PW'(a2), PW'(a1), PW'(a0)};
  endfunction

  task automatic pix(input int v);
    pixel_valid = 1'b1;
    pixel_in    = PW'(v);
    step();
    pixel_valid = 1'b0;
  endtask

  task automatic do_reset();
    n_reset = 1'b1;
    step();
    n_reset = 1'b0;
  endtask

  task automatic cmd_load();
    load_initial = 1'b1;
    step();
    load_initial = 1'b0;
  endtask

  task automatic cmd_move(input logic [1:0] d);
    move_done = 1'b1;
    direction = d;
    step();
    move_done = 1'b0;
    direction = 2'b00;
  endtask

  // Leaves the window at 1..9 and the block back in IDLE.
  task automatic load_1_to_9();
    cmd_load();
    for (int i = 1; i <= 9; i++) pix(i);
    step();
  endtask

  logic [9*PW-1:0] base;

  initial begin
    n_reset = 1'b1; load_initial = 1'b0; move_done = 1'b0;
    direction = 2'b00; pixel_in = '0; pixel_valid = 1'b0;
    base = pk(1, 2, 3, 4, 5, 6, 7, 8, 9);
    step(); step();
    n_reset = 1'b0;

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_pixel_req", pixel_req, 0);
    check("rst_window", window, 0);
    check("rst_window_valid", window_valid, 0);
    check("rst_error", error, 0);

    // Reset in the middle of FILL9
    cmd_load();
    check("fill9_busy", busy, 1);
    check("fill9_pixel_req", pixel_req, 1);
    for (int i = 0; i < 4; i++) pix(8'hA0 + i);
    do_reset();
    check("midrst_busy", busy, 0);
    check("midrst_window", window, 0);
    check("midrst_window_valid", window_valid, 0);
    step();
    check("midrst_no_valid_later", window_valid, 0);

    // Full fill, pixels 1..9 back to back
    cmd_load();
    for (int i = 1; i <= 9; i++) begin
      check("fill9_no_early_valid", window_valid, 0);
      pix(i);
    end
    check("fill9_valid", window_valid, 1);
    check("fill9_window", window, base);
    check("fill9_done_not_busy", busy, 0);
    step();
    check("fill9_valid_one_cycle", window_valid, 0);
    check("fill9_idle_not_busy", busy, 0);

    // pixel_valid in IDLE is ignored
    pix(8'hEE);
    check("idle_pixel_ignored", window, base);
    check("idle_pixel_no_valid", window_valid, 0);

    // Move right: pixels 10, 11, 12
    cmd_move(2'b01);
    check("right_busy", busy, 1);
    pix(10); pix(11);
    check("right_no_early_valid", window_valid, 0);
    pix(12);
    check("right_valid", window_valid, 1);
    check("right_window", window, pk(2, 3, 10, 5, 6, 11, 8, 9, 12));
    step();
    check("right_valid_one_cycle", window_valid, 0);

    // Move down with two-cycle gaps between pixels 20, 21, 22
    do_reset();
    load_1_to_9();
    cmd_move(2'b11);
    for (int i = 0; i < 3; i++) begin
      step();
      check("down_gap_req1", pixel_req, 1);
      step();
      check("down_gap_req2", pixel_req, 1);
      check("down_gap_no_valid", window_valid, 0);
      pix(20 + i);
    end
    check("down_valid", window_valid, 1);
    check("down_window", window, pk(4, 5, 6, 7, 8, 9, 20, 21, 22));
    step();
    check("down_idle_req", pixel_req, 0);

    // Move left: pixels 30, 31, 32
    do_reset();
    load_1_to_9();
    cmd_move(2'b10);
    pix(30); pix(31); pix(32);
    check("left_valid", window_valid, 1);
    check("left_window", window, pk(30, 1, 2, 31, 4, 5, 32, 7, 8));
    step();

    // direction 00 in IDLE: error, nothing else changes
    do_reset();
    load_1_to_9();
    check("err_clear_after_reset", error, 0);
    cmd_move(2'b00);
    check("dir00_error", error, 1);
    check("dir00_not_busy", busy, 0);
    check("dir00_window", window, base);
    step();
    check("dir00_error_sticky", error, 1);
    check("dir00_no_valid", window_valid, 0);

    // move_done during FILL3: error, fill sequence continues unaffected
    do_reset();
    load_1_to_9();
    cmd_move(2'b01);
    pix(40);
    cmd_move(2'b11);
    check("fill3_move_error", error, 1);
    check("fill3_move_still_busy", busy, 1);
    pix(41);
    check("fill3_move_no_early_valid", window_valid, 0);
    pix(42);
    check("fill3_move_valid", window_valid, 1);
    check("fill3_move_window", window, pk(2, 3, 40, 5, 6, 41, 8, 9, 42));
    step();
    check("fill3_move_error_sticky", error, 1);
    check("fill3_move_idle", busy, 0);

    // Reset clears the sticky error
    do_reset();
    check("err_cleared", error, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
